// File: rtl/soc_sram_responder.sv
// SRAM-style responder: word RAM behind an always-on fetch port and a byte-lane data port.
// Reads return through READ_LAT-deep registered pipelines; writes are read-first.
module soc_sram_responder #(
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_addr,
  output logic [31:0]      inst_rdata,
  input  logic             data_en,
  input  logic             data_wen,
  input  logic [3:0]       data_sel,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic [31:0]      data_rdata,
  output logic             addr_err,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]       ipa;
  logic [31:0]       dpa;
  logic              iok;
  logic              dok;
  logic [ADDR_W-1:0] iidx;
  logic [ADDR_W-1:0] didx;
  logic              rd_fire;
  logic              wr_fire;
  logic [31:0]       ird;
  logic [31:0]       drd;

  logic [31:0]         ipd_q [READ_LAT];
  logic [31:0]         dpd_q [READ_LAT];
  logic [READ_LAT-1:0] dpv_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  // Dropping addr[31:29] folds kseg0/kseg1 onto physical space.
  assign ipa  = {3'b000, inst_addr[28:0]};
  assign dpa  = {3'b000, data_addr[28:0]};
  assign iok  = (ipa >> (ADDR_W + 2)) == 32'd0;
  assign dok  = (dpa >> (ADDR_W + 2)) == 32'd0;
  assign iidx = ipa[ADDR_W+1:2];
  assign didx = dpa[ADDR_W+1:2];

  assign rd_fire = data_en & ~data_wen;
  assign wr_fire = data_en & data_wen & dok & (|data_sel);

  assign ird = iok ? mem_q[iidx] : '0;
  assign drd = dok ? mem_q[didx] : '0;

  logic unused_ok;
  assign unused_ok = ^{inst_addr[31:29], data_addr[31:29],
                       dpv_q[READ_LAT-1]};

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sel[b]) mem_q[didx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Last data stage only loads on a valid read, so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        ipd_q[i] <= '0;
        dpd_q[i] <= '0;
      end
      dpv_q <= '0;
    end else begin
      ipd_q[0] <= ird;
      dpv_q[0] <= rd_fire;
      if (rd_fire || READ_LAT > 1) dpd_q[0] <= drd;
      for (int i = 1; i < READ_LAT; i++) begin
        ipd_q[i] <= ipd_q[i-1];
        dpv_q[i] <= dpv_q[i-1];
        if (dpv_q[i-1] || i < READ_LAT - 1) dpd_q[i] <= dpd_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (wr_fire && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (!iok || (data_en && !dok)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign inst_rdata = ipd_q[READ_LAT-1];
  assign data_rdata = dpd_q[READ_LAT-1];
  assign addr_err   = err_q;
  assign wr_count   = cnt_q;

endmodule

// File: tb/tb_soc_sram_responder.sv
// Randomised + directed bench for soc_sram_responder with a queue-based scoreboard.
// Expected values come from a word-map model of the RAM and the address rules.
module tb_soc_sram_responder;

  localparam int AW  = 14;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   inst_addr;
  logic [31:0]   inst_rdata;
  logic          data_en;
  logic          data_wen;
  logic [3:0]    data_sel;
  logic [31:0]   data_addr;
  logic [31:0]   data_wdata;
  logic [31:0]   data_rdata;
  logic          addr_err;
  logic [CW-1:0] wr_count;

  soc_sram_responder #(.ADDR_W(AW), .READ_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wen(data_wen), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .addr_err(addr_err), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          due;
    logic [31:0] v;
    bit          dc;
    bit          e;
  } ev_t;

  ev_t iq[$];
  ev_t dq[$];
  ev_t sq[$];

  logic [31:0] mm [int];
  int          cnt;
  bit          err;

  logic [31:0] ei, ed;
  bit          eidc;
  int          ecnt;
  bit          eerr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a & 32'h1FFF_FFFF) < (32'h1 << (AW + 2));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a & 32'h1FFF_FFFF) >> 2);
  endfunction

  // Called at posedge+1; inputs land on the next edge.
  task automatic step(input logic [31:0] ia, input bit en, input bit wen,
                      input logic [3:0] sel, input logic [31:0] da,
                      input logic [31:0] wd);
    ev_t e;
    int k, i;
    logic [31:0] w;
    inst_addr  = ia;
    data_en    = en;
    data_wen   = wen;
    data_sel   = sel;
    data_addr  = da;
    data_wdata = wd;
    k = edge_n;
    e.due = k + LAT;
    e.e   = 1'b0;
    if (!in_rng(ia)) begin
      e.v = 32'h0; e.dc = 1'b0; err = 1'b1;
    end else begin
      i = widx(ia);
      e.dc = !mm.exists(i);
      e.v  = e.dc ? 32'h0 : mm[i];
    end
    iq.push_back(e);
    if (en) begin
      e.dc = 1'b0;
      if (!in_rng(da)) begin
        err = 1'b1;
        if (!wen) begin e.v = 32'h0; dq.push_back(e); end
      end else if (!wen) begin
        e.v = mm[widx(da)];
        dq.push_back(e);
      end else if (sel != 4'b0000) begin
        i = widx(da);
        w = mm.exists(i) ? mm[i] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (sel[b]) w[8*b +: 8] = wd[8*b +: 8];
        mm[i] = w;
        cnt = (cnt == (1 << CW) - 1) ? cnt : cnt + 1;
      end
    end
    e.due = k + 1;
    e.v   = 32'(cnt);
    e.e   = err;
    e.dc  = 1'b0;
    sq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_en = 1'b0;
    #1;
    iq.delete(); dq.delete(); sq.delete();
    ei = 0; ed = 0; eidc = 0; ecnt = 0; eerr = 0;
    cnt = 0; err = 0;
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (iq.size() > 0 && iq[0].due <= edge_n) begin
        ei = iq[0].v; eidc = iq[0].dc; void'(iq.pop_front());
      end
      while (dq.size() > 0 && dq[0].due <= edge_n) begin
        ed = dq[0].v; void'(dq.pop_front());
      end
      while (sq.size() > 0 && sq[0].due <= edge_n) begin
        ecnt = int'(sq[0].v); eerr = sq[0].e; void'(sq.pop_front());
      end
      if (!eidc) chk("inst_rdata", inst_rdata, ei);
      chk("data_rdata", data_rdata, ed);
      chk("wr_count", 32'(wr_count), 32'(ecnt));
      chk("addr_err", 32'(addr_err), 32'(eerr));
    end
  end

  initial begin
    logic [31:0] old, a, d;
    int op;
    rst = 1'b1;
    inst_addr = 0; data_en = 0; data_wen = 0;
    data_sel = 0; data_addr = 0; data_wdata = 0;
    ei = 0; ed = 0; eidc = 0; ecnt = 0; eerr = 0; cnt = 0; err = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 32; i++)
      step(32'h0, 1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom);

    // Reset with a read in flight
    step(32'h0, 1'b1, 1'b1, 4'hF, 32'h0C, 32'hCAFEF00D);
    step(32'h0, 1'b1, 1'b0, 4'h0, 32'h0C, 32'h0);
    step(32'h0, 1'b1, 1'b0, 4'h0, 32'h0C, 32'h0);
    chk("pre_rst_rdata", data_rdata, 32'hCAFEF00D);
    do_reset();
    repeat (3) idle();

    // Byte-lane merge
    step(32'h0, 1'b1, 1'b1, 4'hF, 32'h8000_0010, 32'h1234_5678);
    step(32'h0, 1'b1, 1'b1, 4'h2, 32'h8000_0010, 32'h0000_AB00);
    step(32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0);
    idle();
    chk("lane_rdata", data_rdata, 32'h1234_AB78);
    chk("lane_count", 32'(wr_count), 32'd2);

    // Latency and kseg1 alias
    step(32'h0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
    step(32'hA000_0020, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    chk("lat_hold", data_rdata, 32'h1234_AB78);
    idle();
    chk("lat_inst", inst_rdata, 32'hDEAD_BEEF);
    chk("lat_data", data_rdata, 32'hDEAD_BEEF);

    // Read-first collision
    old = mm[16];
    step(32'h40, 1'b1, 1'b1, 4'hF, 32'h40, 32'h1111_1111);
    step(32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rf_old", inst_rdata, old);
    idle();
    chk("rf_new", inst_rdata, 32'h1111_1111);

    for (int n = 0; n < 300; n++) begin
      a  = ($urandom & 32'hE000_0003) | 32'(($urandom % 32) << 2);
      d  = ($urandom & 32'hE000_0003) | 32'(($urandom % 32) << 2);
      op = int'($urandom % 3);
      step(a, op != 0, op == 2, 4'($urandom), d, $urandom);
    end
    repeat (3) idle();

    // Out of range
    do_reset();
    step(32'h0, 1'b1, 1'b1, 4'hF, 32'h0001_0000, 32'h5555_AAAA);
    idle();
    chk("oor_err", 32'(addr_err), 32'h1);
    chk("oor_count", 32'(wr_count), 32'h0);
    step(32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    step(32'h0, 1'b1, 1'b0, 4'h0, 32'h8001_0004, 32'h0);
    chk("oor_rd_ok", data_rdata, mm[4]);
    idle();
    chk("oor_rd_zero", data_rdata, 32'h0);
    chk("oor_sticky", 32'(addr_err), 32'h1);

    // Saturation and empty-lane write
    for (int n = 0; n < 20; n++)
      step(32'h0, 1'b1, 1'b1, 4'hF, 32'(($urandom % 32) << 2), $urandom);
    idle();
    chk("sat_count", 32'(wr_count), 32'hF);
    old = mm[5];
    step(32'h0, 1'b1, 1'b1, 4'h0, 32'h14, 32'hFFFF_FFFF);
    step(32'h0, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    idle();
    chk("sel0_data", data_rdata, old);
    chk("sel0_count", 32'(wr_count), 32'hF);
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
